// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the shared-ALU, shared-memory multicycle RV32I datapath.
// Optional memory handshake stalls are enabled by defining CTRL_MEM_WAIT_EN.
module multicycle_controller #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       imm_src,
  output logic [3:0]       alu_control,
  output logic             illegal_instr
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_JAL, S_ALUWB, S_BEQ
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_e     state_q, state_d, cur;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       bit30;
  logic       pc_update, branch, mem_go;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign funct3      = instr[14:12];
  assign bit30       = instr[30];
  assign unused_bits = ^{instr, mem_ready};

`ifdef CTRL_MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  assign mem_go = 1'b1;
`endif

  // sub is only reachable from R-type; sra from both R- and I-type
  function automatic logic [3:0] funct_op(input logic [2:0] f3, input logic b30, input logic is_r);
    case (f3)
      3'b000:  funct_op = (b30 && is_r) ? 4'b0001 : 4'b0000;
      3'b001:  funct_op = 4'b0110;
      3'b010:  funct_op = 4'b0101;
      3'b011:  funct_op = 4'b1001;
      3'b100:  funct_op = 4'b0100;
      3'b101:  funct_op = b30 ? 4'b1000 : 4'b0111;
      3'b110:  funct_op = 4'b0011;
      default: funct_op = 4'b0010;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    case (opcode)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // While reset is low the selects show FETCH and every strobe is suppressed
  always_comb begin
    cur           = rst ? state_q : S_FETCH;
    state_d       = cur;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_control   = 4'b0000;
    illegal_instr = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    case (cur)
      S_FETCH: begin
        ir_write   = mem_go;
        pc_update  = mem_go;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_go) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default: begin
            state_d       = S_FETCH;
            illegal_instr = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_go) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_go) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = funct_op(funct3, bit30, 1'b1);
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = funct_op(funct3, bit30, 1'b0);
        state_d     = S_ALUWB;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a   = 2'b10;
        alu_control = 4'b0001;
        branch      = 1'b1;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (!rst) begin
      ir_write      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      illegal_instr = 1'b0;
      pc_update     = 1'b0;
      branch        = 1'b0;
    end
  end

  assign pc_write = pc_update | (branch & zero);

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control vectors
// are queued when an instruction is issued and compared on each falling edge.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [3:0] alu_control;
    logic       illegal_instr;
  } ctrl_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
  logic [3:0]  alu_control;
  ctrl_t       obs;

  int errors = 0;
  int checks = 0;

  ctrl_t expQ[$];
  string tagQ[$];

  multicycle_controller #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_control(alu_control),
    .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  assign obs = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                alu_src_a, alu_src_b, imm_src, alu_control, illegal_instr};

  function automatic logic [1:0] imm_for(input logic [31:0] ins);
    case (ins[6:0])
      7'b0100011: imm_for = 2'b01;
      7'b1100011: imm_for = 2'b10;
      7'b1101111: imm_for = 2'b11;
      default:    imm_for = 2'b00;
    endcase
  endfunction

  function automatic ctrl_t mk(input logic pcw, input logic adr, input logic mw, input logic irw,
                               input logic rw, input logic [1:0] res, input logic [1:0] a,
                               input logic [1:0] b, input logic [1:0] imm, input logic [3:0] alu,
                               input logic ill);
    ctrl_t c;
    c = {pcw, adr, mw, irw, rw, res, a, b, imm, alu, ill};
    return c;
  endfunction

  function automatic ctrl_t fetch_full(input logic [1:0] imm);
    return mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, imm, 4'b0000, 0);
  endfunction

  function automatic ctrl_t fetch_quiet(input logic [1:0] imm);
    return mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm, 4'b0000, 0);
  endfunction

  task automatic push(input ctrl_t c, input string tag);
    expQ.push_back(c);
    tagQ.push_back(tag);
  endtask

  // Expected cycle-by-cycle sequence for one instruction, from the state table
  task automatic issue(input logic [31:0] ins, input logic z, input logic [3:0] alu);
    logic [1:0] im;
    im    = imm_for(ins);
    instr = ins;
    zero  = z;
    push(fetch_full(im), "fetch");
    case (ins[6:0])
      7'b0000011: begin
        push(mk(0,0,0,0,0,2'b00,2'b01,2'b01,im,4'b0000,0), "lw_decode");
        push(mk(0,0,0,0,0,2'b00,2'b10,2'b01,im,4'b0000,0), "lw_memadr");
        push(mk(0,1,0,0,0,2'b00,2'b00,2'b00,im,4'b0000,0), "lw_memread");
        push(mk(0,0,0,0,1,2'b01,2'b00,2'b00,im,4'b0000,0), "lw_memwb");
      end
      7'b0100011: begin
        push(mk(0,0,0,0,0,2'b00,2'b01,2'b01,im,4'b0000,0), "sw_decode");
        push(mk(0,0,0,0,0,2'b00,2'b10,2'b01,im,4'b0000,0), "sw_memadr");
        push(mk(0,1,1,0,0,2'b00,2'b00,2'b00,im,4'b0000,0), "sw_memwrite");
      end
      7'b0110011: begin
        push(mk(0,0,0,0,0,2'b00,2'b01,2'b01,im,4'b0000,0), "r_decode");
        push(mk(0,0,0,0,0,2'b00,2'b10,2'b00,im,alu,0), "r_execr");
        push(mk(0,0,0,0,1,2'b00,2'b00,2'b00,im,4'b0000,0), "r_aluwb");
      end
      7'b0010011: begin
        push(mk(0,0,0,0,0,2'b00,2'b01,2'b01,im,4'b0000,0), "i_decode");
        push(mk(0,0,0,0,0,2'b00,2'b10,2'b01,im,alu,0), "i_execi");
        push(mk(0,0,0,0,1,2'b00,2'b00,2'b00,im,4'b0000,0), "i_aluwb");
      end
      7'b1101111: begin
        push(mk(0,0,0,0,0,2'b00,2'b01,2'b01,im,4'b0000,0), "jal_decode");
        push(mk(1,0,0,0,0,2'b00,2'b01,2'b10,im,4'b0000,0), "jal_jal");
        push(mk(0,0,0,0,1,2'b00,2'b00,2'b00,im,4'b0000,0), "jal_aluwb");
      end
      7'b1100011: begin
        push(mk(0,0,0,0,0,2'b00,2'b01,2'b01,im,4'b0000,0), "beq_decode");
        push(mk(z,0,0,0,0,2'b00,2'b10,2'b00,im,4'b0001,0), "beq_beq");
      end
      default: push(mk(0,0,0,0,0,2'b00,2'b01,2'b01,im,4'b0000,1), "illegal_decode");
    endcase
  endtask

  // Each queued entry covers one clock cycle: compare on the falling edge
  task automatic drain();
    ctrl_t e;
    string t;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      t = tagQ.pop_front();
      @(negedge clk);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL %s: observed %h expected %h (instr %h)", t, obs, e, instr);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_ready = 1'b1; zero = 1'b0; instr = 32'h002081B3;
    @(posedge clk); #1;
    push(fetch_quiet(2'b00), "reset_hold");
    drain();
    rst = 1'b1;
    issue(32'h002081B3, 1'b0, 4'b0000);
    drain();
  endtask

  task automatic test_rtype();
    logic [31:0] ins [8] = '{32'h402081B3, 32'h0020E1B3, 32'h0020B1B3, 32'h0020C1B3,
                             32'h002091B3, 32'h0020A1B3, 32'h0020D1B3, 32'h4020D1B3};
    logic [3:0]  ops [8] = '{4'b0001, 4'b0011, 4'b1001, 4'b0100,
                             4'b0110, 4'b0101, 4'b0111, 4'b1000};
    for (int i = 0; i < 8; i++) begin
      issue(ins[i], 1'b0, ops[i]);
      drain();
    end
  endtask

  task automatic test_itype();
    issue(32'h40000093, 1'b0, 4'b0000);
    drain();
    issue(32'h4050D093, 1'b0, 4'b1000);
    drain();
    issue(32'h0FF0F093, 1'b0, 4'b0010);
    drain();
  endtask

  task automatic test_load_store();
    issue(32'h00402283, 1'b0, 4'b0000);
    drain();
    issue(32'h00502423, 1'b0, 4'b0000);
    drain();
  endtask

  task automatic test_branch_jal();
    issue(32'h00208463, 1'b1, 4'b0000);
    drain();
    issue(32'h00208463, 1'b0, 4'b0000);
    drain();
    issue(32'h008000EF, 1'b0, 4'b0000);
    drain();
  endtask

  task automatic test_illegal();
    issue(32'h0000007F, 1'b0, 4'b0000);
    drain();
    issue(32'h002081B3, 1'b0, 4'b0000);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq [6] = '{32'h00208463, 32'h00402283, 32'h0000007F,
                             32'h00502423, 32'h008000EF, 32'h0020E1B3};
    logic [3:0]  ops [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0011};
    for (int i = 0; i < 6; i++) begin
      issue(seq[i], i[0], ops[i]);
      drain();
    end
  endtask

  task automatic test_reset_mid();
    // Abandon a store just before its write strobe
    issue(32'h00502423, 1'b0, 4'b0000);
    void'(expQ.pop_back()); void'(tagQ.pop_back());
    drain();
    rst = 1'b0;
    push(fetch_quiet(2'b01), "reset_in_memwrite");
    drain();
    rst = 1'b1;
    // Abandon a load in its writeback cycle
    issue(32'h00402283, 1'b0, 4'b0000);
    void'(expQ.pop_back()); void'(tagQ.pop_back());
    drain();
    rst = 1'b0;
    push(fetch_quiet(2'b00), "reset_in_memwb");
    drain();
    rst = 1'b1;
    issue(32'h002081B3, 1'b0, 4'b0000);
    drain();
  endtask

  task automatic test_mem_ready();
`ifdef CTRL_MEM_WAIT_EN
    mem_ready = 1'b0;
    instr = 32'h002081B3;
    for (int i = 0; i < 3; i++) push(fetch_quiet(2'b00), "fetch_wait");
    drain();
    mem_ready = 1'b1;
    issue(32'h002081B3, 1'b0, 4'b0000);
    drain();
`else
    mem_ready = 1'b0;
    issue(32'h00402283, 1'b0, 4'b0000);
    drain();
    issue(32'h00502423, 1'b0, 4'b0000);
    drain();
    mem_ready = 1'b1;
`endif
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_load_store();
    test_branch_jal();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_mem_ready();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
